// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command receiver: frame width, SPI mode and FSM states.
package spi_pkg;

    localparam int SPI_WIDTH = 64;

    // Mode 0: SCK idles low, MOSI sampled on the rising edge, MISO changes on the falling edge
    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        RX,
        LATCH,
        COMMIT
    } rx_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser for one asynchronous SPI pin, with a history flop for edge strobes.
module spi_sync_edge #(
    parameter int STAGES    = 2,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] chain;
    logic              history;

    // Move the pin through the synchroniser chain and keep the previous synchronised level
    always_ff @(posedge clk) begin
        if (reset) begin
            chain   <= {STAGES{RESET_VAL}};
            history <= RESET_VAL;
        end else begin
            chain   <= {chain[STAGES-2:0], pin};
            history <= chain[STAGES-1];
        end
    end

    assign o_level = chain[STAGES-1];
    assign o_rise  = o_level & ~history;
    assign o_fall  = ~o_level & history;

endmodule

// File: rtl/spi_cmd_rx.sv
// SPI mode-0 slave that deserialises fixed-width command words and returns a status word.
module spi_cmd_rx
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int ERRCNT_W    = 8
) (
    input  logic                CLK,
    input  logic                i_reset,
    input  logic                i_sck,
    input  logic                i_cs_n,
    input  logic                i_mosi,
    input  logic [WIDTH-1:0]    i_status,
    output logic                o_miso,
    output logic [WIDTH-1:0]    o_mem,
    output logic                o_shiftedIn,
    output logic                o_frameErr,
    output logic [ERRCNT_W-1:0] o_errCount
);

    // The counter saturates one past WIDTH so over-length frames never alias to a valid count
    localparam int                 CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(WIDTH + 1);

    logic sck_rise, sck_fall, unused_sck_level;
    logic cs_rise, cs_fall, unused_cs_level;
    logic mosi_level, unused_mosi_rise, unused_mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) sck_sync (
        .clk     (CLK),
        .reset   (i_reset),
        .pin     (i_sck),
        .o_level (unused_sck_level),
        .o_rise  (sck_rise),
        .o_fall  (sck_fall)
    );

    // CS chain resets low so a chip select already asserted at reset release never looks like a frame start
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) cs_sync (
        .clk     (CLK),
        .reset   (i_reset),
        .pin     (i_cs_n),
        .o_level (unused_cs_level),
        .o_rise  (cs_rise),
        .o_fall  (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) mosi_sync (
        .clk     (CLK),
        .reset   (i_reset),
        .pin     (i_mosi),
        .o_level (mosi_level),
        .o_rise  (unused_mosi_rise),
        .o_fall  (unused_mosi_fall)
    );

    rx_state_t        state;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] tx_shift;
    logic [CNT_W-1:0] bit_count;
    logic [CNT_W-1:0] count_next;
    logic             start_pending;

    // Bit count including a sample arriving in this cycle, so a coincident CS rise sees the final count
    always_comb begin
        count_next = bit_count;
        if (sck_rise && (bit_count != CNT_MAX)) begin
            count_next = bit_count + 1'b1;
        end
    end

    // Frame FSM: start on CS fall, shift on SCK strobes, validate length on CS rise, then latch and commit
    always_ff @(posedge CLK) begin
        if (i_reset) begin
            state         <= IDLE;
            rx_shift      <= '0;
            tx_shift      <= '0;
            bit_count     <= '0;
            start_pending <= 1'b0;
            o_mem         <= '0;
            o_shiftedIn   <= 1'b0;
            o_frameErr    <= 1'b0;
            o_errCount    <= '0;
            o_miso        <= 1'b0;
        end else begin
            o_frameErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall || start_pending) begin
                        start_pending <= 1'b0;
                        o_shiftedIn   <= 1'b0;
                        bit_count     <= '0;
                        tx_shift      <= i_status;
                        o_miso        <= i_status[WIDTH-1];
                        state         <= RX;
                    end
                end
                RX: begin
                    if (sck_rise) begin
                        rx_shift  <= {rx_shift[WIDTH-2:0], mosi_level};
                        bit_count <= count_next;
                    end
                    if (sck_fall) begin
                        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                        o_miso   <= tx_shift[WIDTH-2];
                    end
                    if (cs_rise) begin
                        if (count_next == CNT_FULL) begin
                            state <= LATCH;
                        end else begin
                            o_frameErr <= 1'b1;
                            if (o_errCount != {ERRCNT_W{1'b1}}) begin
                                o_errCount <= o_errCount + 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                end
                LATCH: begin
                    o_mem <= rx_shift;
                    if (cs_fall) begin
                        start_pending <= 1'b1;
                    end
                    state <= COMMIT;
                end
                COMMIT: begin
                    o_shiftedIn <= 1'b1;
                    if (cs_fall) begin
                        start_pending <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Self-checking bench for spi_cmd_rx: directed scenarios plus randomized frames against a frame-level model.
module tb_spi_cmd_rx;

    logic        CLK = 1'b0;
    logic        i_reset;
    logic        i_sck;
    logic        i_cs_n;
    logic        i_mosi;
    logic [63:0] i_status;
    logic        o_miso;
    logic [63:0] o_mem;
    logic        o_shiftedIn;
    logic        o_frameErr;
    logic [7:0]  o_errCount;

    spi_cmd_rx dut (
        .CLK         (CLK),
        .i_reset     (i_reset),
        .i_sck       (i_sck),
        .i_cs_n      (i_cs_n),
        .i_mosi      (i_mosi),
        .i_status    (i_status),
        .o_miso      (o_miso),
        .o_mem       (o_mem),
        .o_shiftedIn (o_shiftedIn),
        .o_frameErr  (o_frameErr),
        .o_errCount  (o_errCount)
    );

    // Free-running system clock
    always #5 CLK = ~CLK;

    int          cycle = 0;
    int          cs_fall_cycle = 0;
    int          cs_rise_cycle = 0;
    int          rise_lat = -1;
    int          fall_lat = -1;
    int          err_pulses = 0;
    int          mem_unstable = 0;
    int          pass_checks = 0;
    int          total_checks = 0;
    logic        prev_shifted = 1'b0;
    logic [63:0] prev_mem = '0;
    logic [63:0] miso_cap;
    logic [63:0] commits[$];

    // Count active clock edges so latencies can be measured in CLK cycles
    always @(posedge CLK) cycle++;

    // Observe outputs away from the active edge: commit edges, latencies, error pulses
    always @(negedge CLK) begin
        if (o_shiftedIn === 1'b1 && prev_shifted === 1'b0) begin
            rise_lat = cycle - cs_rise_cycle;
            commits.push_back(o_mem);
            if (o_mem !== prev_mem) mem_unstable++;
        end
        if (o_shiftedIn === 1'b0 && prev_shifted === 1'b1) begin
            fall_lat = cycle - cs_fall_cycle;
        end
        if (o_frameErr === 1'b1) err_pulses++;
        prev_shifted = o_shiftedIn;
        prev_mem     = o_mem;
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total_checks++;
        assert (observed === expected) begin
            pass_checks++;
        end else begin
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Master side of one mode-0 frame; reset_bit >= 0 pulses reset before that bit while CS stays low
    task automatic apply_stimulus(input logic [63:0] word, input logic [63:0] status,
                                  input int nbits, input int half, input int reset_bit);
        @(negedge CLK);
        i_status      = status;
        i_cs_n        = 1'b0;
        cs_fall_cycle = cycle;
        miso_cap      = '0;
        for (int i = 0; i < nbits; i++) begin
            if (i == reset_bit) begin
                i_reset = 1'b1;
                repeat (2) @(negedge CLK);
                i_reset = 1'b0;
            end
            i_mosi = (i < 64) ? word[63-i] : 1'b0;
            repeat (half) @(negedge CLK);
            i_sck = 1'b1;
            if (i < 64) miso_cap = {miso_cap[62:0], o_miso};
            repeat (half) @(negedge CLK);
            i_sck = 1'b0;
        end
        repeat (half) @(negedge CLK);
        i_cs_n        = 1'b1;
        cs_rise_cycle = cycle;
    endtask

    logic [63:0] exp_mem;
    logic [7:0]  exp_err;
    logic        exp_shifted;
    int          exp_pulses;
    int          exp_commits;
    logic [63:0] word_a, word_b, status_r;
    int          len, half;

    // Frame-level model: a frame is accepted exactly when it carries 64 SCK rising edges
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    initial begin
        i_reset  = 1'b1;
        i_sck    = 1'b0;
        i_cs_n   = 1'b1;
        i_mosi   = 1'b0;
        i_status = '0;
        repeat (3) @(negedge CLK);
        i_reset = 1'b0;

        $display("[TB] reset state");
        check_output("reset_mem", o_mem, 64'h0);
        check_output("reset_shiftedIn", {63'h0, o_shiftedIn}, 64'h0);
        check_output("reset_frameErr", {63'h0, o_frameErr}, 64'h0);
        check_output("reset_errCount", {56'h0, o_errCount}, 64'h0);
        check_output("reset_miso", {63'h0, o_miso}, 64'h0);
        exp_mem = '0; exp_err = '0; exp_pulses = 0; exp_commits = 0;
        repeat (5) @(negedge CLK);

        $display("[TB] single valid frame");
        apply_stimulus(64'h0000_0000_0001_4101, 64'h0, 64, 8, -1);
        repeat (20) @(negedge CLK);
        exp_mem = 64'h0000_0000_0001_4101; exp_commits++;
        check_output("t1_mem", o_mem, exp_mem);
        check_output("t1_shiftedIn", {63'h0, o_shiftedIn}, 64'h1);
        check_output("t1_rise_latency", 64'(rise_lat), 64'd5);
        check_output("t1_no_frameErr", 64'(err_pulses), 64'(exp_pulses));
        check_output("t1_commits", 64'(commits.size()), 64'(exp_commits));

        $display("[TB] second frame with status readback");
        apply_stimulus(64'h1000_2005_F00B_E004, 64'hA5A5_0000_FFFF_1234, 64, 8, -1);
        repeat (20) @(negedge CLK);
        exp_mem = 64'h1000_2005_F00B_E004; exp_commits++;
        check_output("t2_fall_latency", 64'(fall_lat), 64'd3);
        check_output("t2_mem", o_mem, exp_mem);
        check_output("t2_miso", miso_cap, 64'hA5A5_0000_FFFF_1234);
        check_output("t2_shiftedIn", {63'h0, o_shiftedIn}, 64'h1);

        $display("[TB] short and long frames");
        apply_stimulus({$urandom, $urandom}, 64'h0, 63, 8, -1);
        repeat (20) @(negedge CLK);
        apply_stimulus({$urandom, $urandom}, 64'h0, 65, 8, -1);
        repeat (20) @(negedge CLK);
        exp_err = 8'd2; exp_pulses += 2;
        check_output("t3_pulses", 64'(err_pulses), 64'(exp_pulses));
        check_output("t3_errCount", {56'h0, o_errCount}, {56'h0, exp_err});
        check_output("t3_mem_kept", o_mem, exp_mem);
        check_output("t3_shiftedIn", {63'h0, o_shiftedIn}, 64'h0);
        check_output("t3_commits", 64'(commits.size()), 64'(exp_commits));

        $display("[TB] reset in mid-frame");
        apply_stimulus({$urandom, $urandom}, 64'h0, 64, 8, 30);
        repeat (20) @(negedge CLK);
        exp_mem = '0; exp_err = '0;
        check_output("t4_mem", o_mem, exp_mem);
        check_output("t4_shiftedIn", {63'h0, o_shiftedIn}, 64'h0);
        check_output("t4_errCount", {56'h0, o_errCount}, {56'h0, exp_err});
        check_output("t4_no_commit", 64'(commits.size()), 64'(exp_commits));
        check_output("t4_pulses", 64'(err_pulses), 64'(exp_pulses));
        apply_stimulus(64'h0, 64'h0, 64, 8, -1);
        repeat (20) @(negedge CLK);
        exp_commits++;
        check_output("t4_zero_commit", 64'(commits.size()), 64'(exp_commits));
        check_output("t4_zero_shiftedIn", {63'h0, o_shiftedIn}, 64'h1);
        check_output("t4_zero_mem", o_mem, 64'h0);

        $display("[TB] back-to-back frames");
        word_a = {$urandom, $urandom};
        word_b = {$urandom, $urandom};
        apply_stimulus(word_a, 64'h0, 64, 8, -1);
        apply_stimulus(word_b, 64'h0, 64, 8, -1);
        repeat (20) @(negedge CLK);
        exp_commits += 2; exp_mem = word_b;
        check_output("t6_commits", 64'(commits.size()), 64'(exp_commits));
        check_output("t6_first_word", commits[commits.size()-2], word_a);
        check_output("t6_second_word", commits[commits.size()-1], word_b);
        check_output("t6_mem", o_mem, exp_mem);

        $display("[TB] randomized frames");
        for (int f = 0; f < 10; f++) begin
            word_a   = {$urandom, $urandom};
            status_r = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: len = 62;
                1: len = 63;
                2: len = 65;
                3: len = 66;
                default: len = 64;
            endcase
            half = int'($urandom_range(4, 9));
            apply_stimulus(word_a, status_r, len, half, -1);
            repeat (20) @(negedge CLK);
            if (len == 64) begin
                exp_mem = word_a; exp_shifted = 1'b1; exp_commits++;
                check_output("rnd_miso", miso_cap, status_r);
            end else begin
                exp_err = sat_inc(exp_err); exp_shifted = 1'b0; exp_pulses++;
            end
            check_output("rnd_mem", o_mem, exp_mem);
            check_output("rnd_errCount", {56'h0, o_errCount}, {56'h0, exp_err});
            check_output("rnd_shiftedIn", {63'h0, o_shiftedIn}, {63'h0, exp_shifted});
            check_output("rnd_commits", 64'(commits.size()), 64'(exp_commits));
        end

        $display("[TB] error counter saturation");
        for (int n = 0; n < 260; n++) begin
            @(negedge CLK);
            i_cs_n = 1'b0;
            repeat (6) @(negedge CLK);
            i_cs_n = 1'b1;
            repeat (6) @(negedge CLK);
            exp_err = sat_inc(exp_err); exp_pulses++;
            if (n == 100) begin
                check_output("t5_mid_errCount", {56'h0, o_errCount}, {56'h0, exp_err});
            end
        end
        repeat (10) @(negedge CLK);
        check_output("t5_saturated", {56'h0, o_errCount}, 64'hFF);
        check_output("t5_pulses", 64'(err_pulses), 64'(exp_pulses));
        check_output("t5_mem_kept", o_mem, exp_mem);
        check_output("mem_stable_before_commit", 64'(mem_unstable), 64'd0);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
